rast_mem_arbiter: RTL and testbench
===================================

Name: rast_mem_arbiter

Overview:
Parametrised N-channel Avalon-MM master arbiter for the rasterizer unit. It merges the vertex-fetch, depth/colour-fetch and pixel write-back masters onto a single SDRAM-controller port. It supports pipelined reads with in-order response routing, so the pipeline stages no longer each need a dedicated bus port.

Parameters:
N_CH, 3, number of upstream master channels (2..8)
ADDR_W, 26, byte address width
DATA_W, 32, data width; byteenable width is DATA_W/8
MAX_PENDING, 8, maximum outstanding reads; power of 2, ≥2

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_address  in  N_CH*ADDR_W  channel i at slice [i*ADDR_W +: ADDR_W]
in_read  in  N_CH  per-channel read request
in_write  in  N_CH  per-channel write request
in_byteenable  in  N_CH*DATA_W/8  per-channel byte enables
in_writedata  in  N_CH*DATA_W  per-channel write data
in_waitrequest  out  N_CH  per-channel waitrequest
in_readdata  out  DATA_W  read data, broadcast to all channels
in_readdatavalid  out  N_CH  one-hot read-data-valid to the owning channel
master_address  out  ADDR_W  to SDRAM controller
master_read  out  1
master_write  out  1
master_byteenable  out  DATA_W/8
master_writedata  out  DATA_W
master_readdata  in  DATA_W
master_readdatavalid  in  1
master_waitrequest  in  1
err_orphan  out  1  sticky: readdatavalid received with no read pending

Behaviour:
- Reset:
  - State is IDLE, RR pointer is 0, ID FIFO is empty, err_orphan is 0.
  - All in_waitrequest bits are 1.
  - master_read, master_write and in_readdatavalid are 0.
  - master_address, master_byteenable and master_writedata are 0.
- FSM IDLE:
  - Channel i is eligible when in_write[i] is high, or when in_read[i] is high and the FIFO is not full.
  - If any channel is eligible, the winner is registered into grant, and the next state is BUSY.
  - Arbitration latency is 1 cycle.
- FSM BUSY:
  - The granted channel's address, read, write, byteenable and writedata pass combinationally to master_*.
  - in_waitrequest[grant] = master_waitrequest. All other in_waitrequest bits = 1.
  - Accept = (master_read | master_write) & ~master_waitrequest.
  - On accept: next state is IDLE and the RR pointer becomes grant+1 mod N_CH.
  - If the granted channel drops both read and write without accept (protocol violation), the FSM returns to IDLE and the pointer does not move.
- Sustained throughput is 1 transfer per 2 cycles.
- Round robin: the search starts at the RR pointer and wraps to 0. The lowest index is searched first only when the pointer is 0.
- Simultaneous read and write from one channel: the write is issued first. The read stays pending and the channel is re-arbitrated later.
- Read tracking:
  - A read accept pushes grant into the ID FIFO.
  - master_readdatavalid pops the FIFO head and sets in_readdatavalid[head]=1 for that cycle.
  - in_readdata = master_readdata, combinational, with 0 added latency.
- FIFO boundaries:
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - When the FIFO is full, reads are not eligible (writes still are).
  - A read already granted in BUSY can never overflow the FIFO, because eligibility was checked at grant time.
- Orphan response: readdatavalid with the FIFO empty drives no in_readdatavalid and sets err_orphan. err_orphan is cleared only by reset.
- Reset mid-operation: outstanding IDs are discarded, and subsequent orphan responses set err_orphan. The upstream channels must also be reset.

Optional Feature:
RAST_ARB_FIXED_PRIO_EN
- Defined: fixed priority, where the lowest channel index always wins. The RR pointer is removed. This lets pixel write-back (channel 0) starve fetch under load.
- Undefined: round robin as above.

Decomposition:
- Package rast_arb_pkg holds:
  - state enum {IDLE, BUSY}
  - localparams CH_W=$clog2(N_CH) and PEND_W=$clog2(MAX_PENDING)+1
  - function rr_pick(req, ptr), returning the winner index
- Sub-module rast_id_fifo: synchronous FIFO, CH_W wide and MAX_PENDING deep, with full/empty/count outputs and simultaneous push/pop support.

Test Plan:
1. Channel 1 writes alone to 0x0000100, data 0xDEADBEEF, byteenable 0xF, master_waitrequest=0 → the master write appears 1 cycle after request. in_waitrequest[1] falls for exactly 1 cycle. RR pointer = 2.
2. All 3 channels write continuously, waitrequest=0 → grants follow 0,1,2,0,1,2. Each channel gets 1 accept per 6 cycles. With RAST_ARB_FIXED_PRIO_EN defined, only channel 0 is served.
3. Channel 2 reads A, channel 0 reads B; the slave returns 0x11 then 0x22 with readdatavalid 4 cycles later → in_readdatavalid asserts 3'b100 carrying 0x11, then 3'b001 carrying 0x22.
4. Channel 0 issues 8 reads with no responses → the 9th read is held with waitrequest=1. A channel 1 write is still granted. One response releases the read the next cycle.
5. master_waitrequest is held high for 5 cycles during a granted write → the master_* signals are stable for all 5 cycles, other channels stay waitrequest=1, and the accept happens on the 6th cycle.
6. Reset is asserted with 3 reads pending, then 1 readdatavalid arrives after reset → no in_readdatavalid is driven, err_orphan=1 and stays set.

Source files
------------

// File: rtl/rast_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rast_arb_pkg
// Brief    : Shared types, default sizes and round-robin picker for the
//            rasterizer memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rast_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int N_CH_DEF        = 3;
    localparam int MAX_PENDING_DEF = 8;
    localparam int CH_W            = $clog2(N_CH_DEF);
    localparam int PEND_W          = $clog2(MAX_PENDING_DEF) + 1;
    localparam int MAX_CH          = 8;

    // Search starts at ptr and wraps to 0; req bits at or above n_ch are ignored.
    function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                           input logic [2:0]        ptr,
                                           input int                n_ch);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n_ch) begin
                idx = idx - n_ch;
            end
            if (!found && (k < n_ch) && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rast_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rast_id_fifo
// Brief    : Synchronous FIFO of channel IDs for in-order read-response routing.
// Revision : 1.0 - initial release
// ============================================================================
module rast_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rast_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rast_mem_arbiter
// Brief    : N-channel Avalon-MM arbiter onto one SDRAM port with pipelined,
//            in-order read routing. Define RAST_ARB_FIXED_PRIO_EN for fixed
//            priority (channel 0 highest) instead of round robin.
// Revision : 1.0 - initial release
// ============================================================================
module rast_mem_arbiter #(
    parameter int N_CH        = 3,
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH*ADDR_W-1:0]   in_address,
    input  logic [N_CH-1:0]          in_read,
    input  logic [N_CH-1:0]          in_write,
    input  logic [N_CH*DATA_W/8-1:0] in_byteenable,
    input  logic [N_CH*DATA_W-1:0]   in_writedata,
    output logic [N_CH-1:0]          in_waitrequest,
    output logic [DATA_W-1:0]        in_readdata,
    output logic [N_CH-1:0]          in_readdatavalid,
    output logic [ADDR_W-1:0]        master_address,
    output logic                     master_read,
    output logic                     master_write,
    output logic [DATA_W/8-1:0]      master_byteenable,
    output logic [DATA_W-1:0]        master_writedata,
    input  logic [DATA_W-1:0]        master_readdata,
    input  logic                     master_readdatavalid,
    input  logic                     master_waitrequest,
    output logic                     err_orphan
);

    import rast_arb_pkg::*;

    localparam int CHB   = $clog2(N_CH);
    localparam int PENDB = $clog2(MAX_PENDING) + 1;
    localparam int BE_W  = DATA_W / 8;

    state_e           state_q;
    logic [CHB-1:0]   grant_q;
    logic             err_orphan_q;

    logic [N_CH-1:0]  w_elig;
    logic             w_room;
    logic             w_busy;
    logic             w_g_wr;
    logic             w_g_rd;
    logic             w_acc;
    logic             w_push;
    logic             w_pop;
    logic [CHB-1:0]   w_pick;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CHB-1:0]   fifo_head;
    logic [PENDB-1:0] fifo_count;

    assign w_room = (fifo_count < PENDB'(MAX_PENDING));
    assign w_elig = in_write | (in_read & {N_CH{w_room}});
    assign w_busy = (state_q == BUSY);

    // Write wins over a simultaneous read; the read is re-arbitrated later.
    assign w_g_wr = w_busy & in_write[grant_q];
    assign w_g_rd = w_busy & in_read[grant_q] & ~in_write[grant_q] & ~fifo_full;
    assign w_acc  = (w_g_rd | w_g_wr) & ~master_waitrequest;
    assign w_push = w_acc & w_g_rd;
    assign w_pop  = master_readdatavalid & ~fifo_empty;

`ifdef RAST_ARB_FIXED_PRIO_EN
    assign w_pick = CHB'(rr_pick(MAX_CH'(w_elig), 3'd0, N_CH));
`else
    logic [CHB-1:0] ptr_q;
    assign w_pick = CHB'(rr_pick(MAX_CH'(w_elig), 3'(ptr_q), N_CH));
`endif

    always_comb begin
        master_address    = '0;
        master_byteenable = '0;
        master_writedata  = '0;
        in_waitrequest    = '1;
        if (w_busy) begin
            master_address          = in_address[int'(grant_q)*ADDR_W +: ADDR_W];
            master_byteenable       = in_byteenable[int'(grant_q)*BE_W +: BE_W];
            master_writedata        = in_writedata[int'(grant_q)*DATA_W +: DATA_W];
            in_waitrequest[grant_q] = master_waitrequest;
        end
    end

    assign master_read  = w_g_rd;
    assign master_write = w_g_wr;

    always_comb begin
        in_readdatavalid = '0;
        if (w_pop) begin
            in_readdatavalid[fifo_head] = 1'b1;
        end
    end

    assign in_readdata = master_readdata;
    assign err_orphan  = err_orphan_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            err_orphan_q <= 1'b0;
`ifndef RAST_ARB_FIXED_PRIO_EN
            ptr_q        <= '0;
`endif
        end else begin
            if (master_readdatavalid && fifo_empty) begin
                err_orphan_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (|w_elig) begin
                        grant_q <= w_pick;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_acc) begin
                        state_q <= IDLE;
`ifndef RAST_ARB_FIXED_PRIO_EN
                        ptr_q   <= (grant_q == CHB'(N_CH - 1)) ? '0 : grant_q + 1'b1;
`endif
                    end else if (!w_g_rd && !w_g_wr) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    rast_id_fifo #(
        .WIDTH (CHB),
        .DEPTH (MAX_PENDING)
    ) u_id_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (w_push),
        .push_data_i (grant_q),
        .pop_i       (w_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_rast_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rast_mem_arbiter
// Brief    : Directed self-checking bench for rast_mem_arbiter (round robin).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rast_mem_arbiter;

    localparam int N_CH   = 3;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [ADDR_W-1:0] addr  [N_CH];
    logic [DATA_W-1:0] wdata [N_CH];
    logic [BE_W-1:0]   be    [N_CH];
    logic [N_CH-1:0]   rd;
    logic [N_CH-1:0]   wr;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rdv;
    logic              m_wait;

    logic [N_CH*ADDR_W-1:0] in_address;
    logic [N_CH*BE_W-1:0]   in_byteenable;
    logic [N_CH*DATA_W-1:0] in_writedata;
    logic [N_CH-1:0]        in_waitrequest;
    logic [DATA_W-1:0]      in_readdata;
    logic [N_CH-1:0]        in_readdatavalid;
    logic [ADDR_W-1:0]      master_address;
    logic                   master_read;
    logic                   master_write;
    logic [BE_W-1:0]        master_byteenable;
    logic [DATA_W-1:0]      master_writedata;
    logic                   err_orphan;

    int n_vec = 0;
    int n_err = 0;

    assign in_address    = {addr[2], addr[1], addr[0]};
    assign in_byteenable = {be[2], be[1], be[0]};
    assign in_writedata  = {wdata[2], wdata[1], wdata[0]};

    always #5 clock = ~clock;

    rast_mem_arbiter #(
        .N_CH        (N_CH),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_PENDING (8)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .in_address           (in_address),
        .in_read              (rd),
        .in_write             (wr),
        .in_byteenable        (in_byteenable),
        .in_writedata         (in_writedata),
        .in_waitrequest       (in_waitrequest),
        .in_readdata          (in_readdata),
        .in_readdatavalid     (in_readdatavalid),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_byteenable    (master_byteenable),
        .master_writedata     (master_writedata),
        .master_readdata      (m_rdata),
        .master_readdatavalid (m_rdv),
        .master_waitrequest   (m_wait),
        .err_orphan           (err_orphan)
    );

    task automatic test_reset();
        rd = '0; wr = '0; m_rdata = '0; m_rdv = 1'b0; m_wait = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            addr[c] = '0; wdata[c] = '0; be[c] = '0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        n_vec++; if (in_waitrequest !== 3'b111) begin n_err++; $display("FAIL reset_waitreq: got %b want 111", in_waitrequest); end
        n_vec++; if ({master_read, master_write} !== 2'b00) begin n_err++; $display("FAIL reset_rw: got %b want 00", {master_read, master_write}); end
        n_vec++; if (in_readdatavalid !== 3'b000) begin n_err++; $display("FAIL reset_rdv: got %b want 000", in_readdatavalid); end
        n_vec++; if ({master_address, master_byteenable, master_writedata} !== '0) begin n_err++; $display("FAIL reset_bus: got %h/%h/%h want 0", master_address, master_byteenable, master_writedata); end
        n_vec++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL reset_orphan: got %b want 0", err_orphan); end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clock);
        wr = 3'b010; addr[1] = 26'h0000100; wdata[1] = 32'hDEADBEEF; be[1] = 4'hF;
        #1;
        n_vec++; if (master_write !== 1'b0) begin n_err++; $display("FAIL sw_idle_write: got %b want 0", master_write); end
        @(negedge clock); #1;
        n_vec++; if (master_write !== 1'b1) begin n_err++; $display("FAIL sw_write: got %b want 1", master_write); end
        n_vec++; if (master_address !== 26'h0000100) begin n_err++; $display("FAIL sw_addr: got %h want 0000100", master_address); end
        n_vec++; if (master_writedata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_data: got %h want deadbeef", master_writedata); end
        n_vec++; if (master_byteenable !== 4'hF) begin n_err++; $display("FAIL sw_be: got %h want f", master_byteenable); end
        n_vec++; if (in_waitrequest !== 3'b101) begin n_err++; $display("FAIL sw_waitreq_low: got %b want 101", in_waitrequest); end
        @(negedge clock); #1;
        n_vec++; if (in_waitrequest !== 3'b111) begin n_err++; $display("FAIL sw_waitreq_one_cycle: got %b want 111", in_waitrequest); end
        wr = 3'b000;
        @(negedge clock); #1;
        n_vec++; if (master_write !== 1'b0) begin n_err++; $display("FAIL sw_done: got %b want 0", master_write); end
    endtask

    // Pointer sits at 2 after the channel-1 write, so the rotation starts at channel 2.
    task automatic test_round_robin();
        int seq [6] = '{2, 0, 1, 2, 0, 1};
        int acc [N_CH];
        logic [N_CH-1:0] exp_wr;
        for (int c = 0; c < N_CH; c++) begin
            acc[c] = 0; addr[c] = ADDR_W'(26'h1000 + c); wdata[c] = DATA_W'(32'hA0 + c); be[c] = 4'hF;
        end
        @(negedge clock);
        wr = 3'b111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock); #1;
            if (k % 2 == 0) begin
                exp_wr = 3'b111 & ~(3'b001 << seq[k/2]);
                n_vec++; if (master_writedata !== wdata[seq[k/2]]) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", k, master_writedata, wdata[seq[k/2]]); end
            end else begin
                exp_wr = 3'b111;
            end
            n_vec++; if (in_waitrequest !== exp_wr) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, in_waitrequest, exp_wr); end
            for (int c = 0; c < N_CH; c++) begin
                if (in_waitrequest[c] == 1'b0) acc[c]++;
            end
            if (k == 11) wr = 3'b000;
        end
        for (int c = 0; c < N_CH; c++) begin
            n_vec++; if (acc[c] != 2) begin n_err++; $display("FAIL rr_accepts[%0d]: got %0d want 2", c, acc[c]); end
        end
    endtask

    task automatic test_read_routing();
        @(negedge clock);
        rd = 3'b101; addr[2] = 26'h0000A00; addr[0] = 26'h0000B00;
        @(negedge clock); #1;
        n_vec++; if ({master_read, master_address} !== {1'b1, 26'h0000A00}) begin n_err++; $display("FAIL rd_first: got %b/%h want 1/0000a00", master_read, master_address); end
        n_vec++; if (in_waitrequest !== 3'b011) begin n_err++; $display("FAIL rd_first_wait: got %b want 011", in_waitrequest); end
        @(negedge clock);
        rd[2] = 1'b0;
        @(negedge clock); #1;
        n_vec++; if ({master_read, master_address} !== {1'b1, 26'h0000B00}) begin n_err++; $display("FAIL rd_second: got %b/%h want 1/0000b00", master_read, master_address); end
        n_vec++; if (in_waitrequest !== 3'b110) begin n_err++; $display("FAIL rd_second_wait: got %b want 110", in_waitrequest); end
        @(negedge clock);
        rd[0] = 1'b0;
        repeat (3) @(negedge clock);
        m_rdv = 1'b1; m_rdata = 32'h11; #1;
        n_vec++; if ({in_readdatavalid, in_readdata} !== {3'b100, 32'h11}) begin n_err++; $display("FAIL rd_resp0: got %b/%h want 100/00000011", in_readdatavalid, in_readdata); end
        @(negedge clock);
        m_rdata = 32'h22; #1;
        n_vec++; if ({in_readdatavalid, in_readdata} !== {3'b001, 32'h22}) begin n_err++; $display("FAIL rd_resp1: got %b/%h want 001/00000022", in_readdatavalid, in_readdata); end
        @(negedge clock);
        m_rdv = 1'b0; #1;
        n_vec++; if ({in_readdatavalid, err_orphan} !== 4'b0000) begin n_err++; $display("FAIL rd_quiet: got %b/%b want 000/0", in_readdatavalid, err_orphan); end
    endtask

    task automatic test_fifo_full();
        logic [N_CH-1:0] exp_wr;
        @(negedge clock);
        rd = 3'b001; addr[0] = 26'h0000C00;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock); #1;
            exp_wr = (k % 2 == 0) ? 3'b110 : 3'b111;
            n_vec++; if (in_waitrequest !== exp_wr) begin n_err++; $display("FAIL full_fill[%0d]: got %b want %b", k, in_waitrequest, exp_wr); end
        end
        repeat (3) begin
            @(negedge clock); #1;
            n_vec++; if ({in_waitrequest, master_read} !== 4'b1110) begin n_err++; $display("FAIL full_hold: got %b/%b want 111/0", in_waitrequest, master_read); end
        end
        @(negedge clock);
        wr[1] = 1'b1; addr[1] = 26'h0000D40; wdata[1] = 32'h5555AAAA;
        @(negedge clock); #1;
        n_vec++; if ({in_waitrequest, master_write, master_read} !== 5'b10110) begin n_err++; $display("FAIL full_write_ok: got %b/%b/%b want 101/1/0", in_waitrequest, master_write, master_read); end
        @(negedge clock);
        wr[1] = 1'b0; m_rdv = 1'b1; m_rdata = 32'h33; #1;
        n_vec++; if (in_readdatavalid !== 3'b001) begin n_err++; $display("FAIL full_resp: got %b want 001", in_readdatavalid); end
        @(negedge clock);
        m_rdv = 1'b0; #1;
        n_vec++; if (in_waitrequest !== 3'b111) begin n_err++; $display("FAIL full_rearb: got %b want 111", in_waitrequest); end
        @(negedge clock); #1;
        n_vec++; if ({in_waitrequest, master_read} !== 4'b1101) begin n_err++; $display("FAIL full_release: got %b/%b want 110/1", in_waitrequest, master_read); end
        @(negedge clock);
        rd = 3'b000;
        for (int k = 0; k < 8; k++) begin
            m_rdv = 1'b1; m_rdata = DATA_W'(k); #1;
            n_vec++; if (in_readdatavalid !== 3'b001) begin n_err++; $display("FAIL full_drain[%0d]: got %b want 001", k, in_readdatavalid); end
            @(negedge clock);
        end
        m_rdv = 1'b0; #1;
        n_vec++; if ({in_readdatavalid, err_orphan} !== 4'b0000) begin n_err++; $display("FAIL full_drained: got %b/%b want 000/0", in_readdatavalid, err_orphan); end
    endtask

    task automatic test_waitrequest_stall();
        @(negedge clock);
        m_wait = 1'b1; wr = 3'b101;
        addr[2] = 26'h00002AC; wdata[2] = 32'hCAFEF00D; be[2] = 4'b0110;
        addr[0] = 26'h00003F0; wdata[0] = 32'h01234567; be[0] = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock); #1;
            n_vec++; if ({master_write, master_address, master_writedata, master_byteenable} !== {1'b1, 26'h00002AC, 32'hCAFEF00D, 4'b0110}) begin
                n_err++; $display("FAIL stall_stable[%0d]: got %b/%h/%h/%h want 1/00002ac/cafef00d/6", k, master_write, master_address, master_writedata, master_byteenable);
            end
            n_vec++; if (in_waitrequest !== 3'b111) begin n_err++; $display("FAIL stall_wait[%0d]: got %b want 111", k, in_waitrequest); end
        end
        @(negedge clock);
        m_wait = 1'b0; #1;
        n_vec++; if (in_waitrequest !== 3'b011) begin n_err++; $display("FAIL stall_accept: got %b want 011", in_waitrequest); end
        @(negedge clock);
        wr[2] = 1'b0; #1;
        n_vec++; if (in_waitrequest !== 3'b111) begin n_err++; $display("FAIL stall_idle: got %b want 111", in_waitrequest); end
        @(negedge clock); #1;
        n_vec++; if ({in_waitrequest, master_writedata} !== {3'b110, 32'h01234567}) begin n_err++; $display("FAIL stall_next: got %b/%h want 110/01234567", in_waitrequest, master_writedata); end
        @(negedge clock);
        wr = 3'b000;
    endtask

    task automatic test_reset_orphan();
        @(negedge clock);
        rd = 3'b010; addr[1] = 26'h0000E00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock); #1;
            if (k % 2 == 0) begin
                n_vec++; if (in_waitrequest !== 3'b101) begin n_err++; $display("FAIL orph_issue[%0d]: got %b want 101", k, in_waitrequest); end
            end
            if (k == 5) rd = 3'b000;
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; #1;
        n_vec++; if ({in_waitrequest, err_orphan} !== 4'b1110) begin n_err++; $display("FAIL orph_after_reset: got %b/%b want 111/0", in_waitrequest, err_orphan); end
        @(negedge clock);
        m_rdv = 1'b1; m_rdata = 32'h77; #1;
        n_vec++; if (in_readdatavalid !== 3'b000) begin n_err++; $display("FAIL orph_rdv: got %b want 000", in_readdatavalid); end
        @(negedge clock);
        m_rdv = 1'b0; #1;
        n_vec++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orph_set: got %b want 1", err_orphan); end
        repeat (3) @(negedge clock);
        #1;
        n_vec++; if ({err_orphan, in_readdatavalid} !== 4'b1000) begin n_err++; $display("FAIL orph_sticky: got %b/%b want 1/000", err_orphan, in_readdatavalid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached without completion, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_routing();
        test_fifo_full();
        test_waitrequest_stall();
        test_reset_orphan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
